// File: rtl/reset_seq.sv
// Multi-stage reset sequencer: stretch, staggered stage releases, then a Z80
// bus request/acknowledge handshake with timeout before the hold reset drops.
module reset_seq #(
  parameter int N_STAGES   = 3,
  parameter int STRETCH    = 256,
  parameter int STAGE_GAP  = 16,
  parameter int TMO_CYCLES = 65535
) (
  input  logic                clk_fpga,
  input  logic                rst,
  input  logic                init,
  output logic [N_STAGES-1:0] stage_rst_n,
  output logic                z80_busrq_n,
  input  logic                z80_busak_n,
  output logic                hold_rst_n,
  output logic                init_in_progress,
  output logic                timeout
);

  localparam int MAXC_A = (STRETCH > STAGE_GAP) ? STRETCH : STAGE_GAP;
  localparam int MAXC   = (MAXC_A > TMO_CYCLES) ? MAXC_A : TMO_CYCLES;
  localparam int CW     = $clog2(MAXC + 1) + 1;

  localparam logic [CW-1:0] C_STRETCH = CW'(STRETCH);
  localparam logic [CW-1:0] C_GAP_M1  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] C_TMO_M1  = CW'(TMO_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_STAGE = 3'd1,
    S_BUSRQ = 3'd2,
    S_DONE  = 3'd3,
    S_TMO   = 3'd4
  } state_t;

  state_t              r_state, w_state_nx;
  logic [CW-1:0]       r_cnt, w_cnt_nx;
  logic [N_STAGES-1:0] r_stage_rst_n, w_stage_rst_n_nx;
  logic                r_busrq_n, w_busrq_n_nx;
  logic                r_hold_rst_n, w_hold_rst_n_nx;
  logic                r_iip, w_iip_nx;
  logic                r_timeout, w_timeout_nx;
  logic                r_ack_s1, r_ack_s2;

  // Acknowledge comes from another clock domain; idle level is high.
  always_ff @(posedge clk_fpga or posedge rst) begin
    if (rst) begin
      r_ack_s1 <= 1'b1;
      r_ack_s2 <= 1'b1;
    end else begin
      r_ack_s1 <= z80_busak_n;
      r_ack_s2 <= r_ack_s1;
    end
  end

  always_ff @(posedge clk_fpga or posedge rst) begin
    if (rst) begin
      r_state       <= S_HOLD;
      r_cnt         <= '0;
      r_stage_rst_n <= '0;
      r_busrq_n     <= 1'b1;
      r_hold_rst_n  <= 1'b0;
      r_iip         <= 1'b1;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_stage_rst_n <= w_stage_rst_n_nx;
      r_busrq_n     <= w_busrq_n_nx;
      r_hold_rst_n  <= w_hold_rst_n_nx;
      r_iip         <= w_iip_nx;
      r_timeout     <= w_timeout_nx;
    end
  end

  always_comb begin
    w_state_nx       = r_state;
    w_cnt_nx         = r_cnt;
    w_stage_rst_n_nx = r_stage_rst_n;
    w_busrq_n_nx     = r_busrq_n;
    w_hold_rst_n_nx  = r_hold_rst_n;
    w_iip_nx         = r_iip;
    w_timeout_nx     = r_timeout;

    if (init) begin
      w_state_nx       = S_HOLD;
      w_cnt_nx         = '0;
      w_stage_rst_n_nx = '0;
      w_busrq_n_nx     = 1'b1;
      w_hold_rst_n_nx  = 1'b0;
      w_iip_nx         = 1'b1;
      w_timeout_nx     = 1'b0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_cnt == C_STRETCH) begin
            w_state_nx       = S_STAGE;
            w_cnt_nx         = '0;
            w_stage_rst_n_nx = (r_stage_rst_n << 1) | N_STAGES'(1);
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
        // Stages release as a thermometer code; the top bit marks completion.
        S_STAGE: begin
          if (r_stage_rst_n[N_STAGES-1]) begin
            w_state_nx   = S_BUSRQ;
            w_cnt_nx     = '0;
            w_busrq_n_nx = 1'b0;
          end else if (r_cnt == C_GAP_M1) begin
            w_cnt_nx         = '0;
            w_stage_rst_n_nx = (r_stage_rst_n << 1) | N_STAGES'(1);
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
        // Acknowledge is tested first so it wins over a simultaneous timeout.
        S_BUSRQ: begin
          if (!r_ack_s2) begin
            w_state_nx      = S_DONE;
            w_cnt_nx        = '0;
            w_hold_rst_n_nx = 1'b1;
            w_iip_nx        = 1'b0;
          end else if (r_cnt == C_TMO_M1) begin
            w_state_nx   = S_TMO;
            w_cnt_nx     = '0;
            w_busrq_n_nx = 1'b1;
            w_timeout_nx = 1'b1;
            w_iip_nx     = 1'b0;
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
        S_DONE: w_state_nx = S_DONE;
        S_TMO:  w_state_nx = S_TMO;
        default: begin
          w_state_nx = S_HOLD;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  assign stage_rst_n      = r_stage_rst_n;
  assign z80_busrq_n      = r_busrq_n;
  assign hold_rst_n       = r_hold_rst_n;
  assign init_in_progress = r_iip;
  assign timeout          = r_timeout;

endmodule
